// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - Writeback FIFO merging ALU and load results into one register-file write port
// Forward lookup covers queued entries plus the output register, youngest match wins.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        in_ready,
  output logic        EnableWrite,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic        fwd1_hit,
  output logic [31:0] fwd1_data,
  output logic        fwd2_hit,
  output logic [31:0] fwd2_data,
  output logic [2:0]  pending,
  output logic        overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    q_reg  [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          mem_en;
  logic          alu_en;
  logic          pop;
  logic [CW-1:0] n_enq;
  logic [PW-1:0] alu_slot;

  assign in_ready = (count <= CW'(DEPTH - 2));
  assign pending  = 3'(count);
  assign mem_en   = in_ready && mem_valid && (mem_reg != 5'd0);
  assign alu_en   = in_ready && alu_valid && (alu_reg != 5'd0);
  assign pop      = (count != '0);
  assign n_enq    = CW'(mem_en) + CW'(alu_en);
  // The load is the older instruction, so it takes the first free slot.
  assign alu_slot = mem_en ? tail + PW'(1) : tail;

  always_ff @(posedge clk) begin
    if (mem_en) begin
      q_reg[tail]  <= mem_reg;
      q_data[tail] <= mem_data;
    end
    if (alu_en) begin
      q_reg[alu_slot]  <= alu_reg;
      q_data[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      EnableWrite <= 1'b0;
      write_reg   <= 5'd0;
      write_data  <= 32'd0;
      overflow    <= 1'b0;
    end else begin
      // Pop uses pre-edge count, so an entry written this edge waits one cycle.
      if (pop) begin
        write_reg  <= q_reg[head];
        write_data <= q_data[head];
        head       <= head + PW'(1);
      end
      EnableWrite <= pop;
      tail        <= tail + PW'(n_enq);
      count       <= count + n_enq - CW'(pop);
      if (!in_ready && (alu_valid || mem_valid)) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    logic [PW-1:0] idx;
    idx       = head;
    fwd1_hit  = 1'b0;
    fwd1_data = 32'd0;
    fwd2_hit  = 1'b0;
    fwd2_data = 32'd0;
    if (EnableWrite && write_reg == read_reg1) begin
      fwd1_hit  = 1'b1;
      fwd1_data = write_data;
    end
    if (EnableWrite && write_reg == read_reg2) begin
      fwd2_hit  = 1'b1;
      fwd2_data = write_data;
    end
    // Walk oldest to youngest so later matches override earlier ones.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (q_reg[idx] == read_reg1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = q_data[idx];
        end
        if (q_reg[idx] == read_reg2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = q_data[idx];
        end
      end
    end
    if (read_reg1 == 5'd0) begin
      fwd1_hit  = 1'b0;
      fwd1_data = 32'd0;
    end
    if (read_reg2 == 5'd0) begin
      fwd2_hit  = 1'b0;
      fwd2_data = 32'd0;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - Directed-vector bench for writeback_queue (DEPTH=4)
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        in_ready;
  logic        EnableWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [2:0]  pending;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  int ew_pulses;

  writeback_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
    .in_ready(in_ready), .EnableWrite(EnableWrite),
    .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_reg = 5'd0; mem_data = 32'd0;
  endtask

  task automatic send_alu(input logic [4:0] r, input logic [31:0] d);
    alu_valid = 1'b1; alu_reg = r; alu_data = d;
  endtask

  task automatic send_mem(input logic [4:0] r, input logic [31:0] d);
    mem_valid = 1'b1; mem_reg = r; mem_data = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;
    #2;
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ew", 32'(EnableWrite), 32'd0);
    check("rst_wreg", 32'(write_reg), 32'd0);
    check("rst_wdata", write_data, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_fwd1", 32'(fwd1_hit), 32'd0);
    #6 rst = 1'b0;

    // single write
    send_alu(5'd9, 32'h11);
    tick();
    idle();
    read_reg1 = 5'd9;
    #1;
    check("sw_pend1", 32'(pending), 32'd1);
    check("sw_ew0", 32'(EnableWrite), 32'd0);
    check("sw_fwd_hit", 32'(fwd1_hit), 32'd1);
    check("sw_fwd_data", fwd1_data, 32'h11);
    tick();
    check("sw_ew", 32'(EnableWrite), 32'd1);
    check("sw_wreg", 32'(write_reg), 32'd9);
    check("sw_wdata", write_data, 32'h11);
    check("sw_pend0", 32'(pending), 32'd0);
    check("sw_fwd_outreg", fwd1_data, 32'h11);
    tick();
    check("sw_ew_off", 32'(EnableWrite), 32'd0);
    check("sw_wreg_hold", 32'(write_reg), 32'd9);
    check("sw_fwd_gone", 32'(fwd1_hit), 32'd0);

    // dual issue ordering
    send_mem(5'd10, 32'hAA);
    send_alu(5'd10, 32'hBB);
    read_reg1 = 5'd10;
    tick();
    idle();
    #1;
    check("dual_pend2", 32'(pending), 32'd2);
    check("dual_fwd", fwd1_data, 32'hBB);
    tick();
    check("dual_w1", write_data, 32'hAA);
    check("dual_pend1", 32'(pending), 32'd1);
    check("dual_fwd_young", fwd1_data, 32'hBB);
    tick();
    check("dual_w2", write_data, 32'hBB);
    check("dual_ew2", 32'(EnableWrite), 32'd1);
    check("dual_pend0", 32'(pending), 32'd0);
    tick();
    check("dual_ew_off", 32'(EnableWrite), 32'd0);

    // zero register
    send_alu(5'd0, 32'hFF);
    read_reg1 = 5'd0;
    tick();
    idle();
    #1;
    check("zero_pend", 32'(pending), 32'd0);
    check("zero_ew", 32'(EnableWrite), 32'd0);
    check("zero_fwd", 32'(fwd1_hit), 32'd0);
    tick();
    check("zero_ew2", 32'(EnableWrite), 32'd0);

    // full / backpressure
    send_mem(5'd1, 32'h101);
    send_alu(5'd2, 32'h102);
    tick();
    check("full_pend2", 32'(pending), 32'd2);
    check("full_ready2", 32'(in_ready), 32'd1);
    send_mem(5'd3, 32'h103);
    send_alu(5'd4, 32'h104);
    tick();
    idle();
    #1;
    check("full_pend3", 32'(pending), 32'd3);
    check("full_ready0", 32'(in_ready), 32'd0);
    check("full_ovf0", 32'(overflow), 32'd0);
    check("full_w1", write_data, 32'h101);
    send_alu(5'd5, 32'h105);
    read_reg2 = 5'd5;
    tick();
    idle();
    #1;
    check("full_ovf1", 32'(overflow), 32'd1);
    check("full_w2", write_data, 32'h102);
    check("full_drop_fwd", 32'(fwd2_hit), 32'd0);
    tick();
    check("full_w3", write_data, 32'h103);
    tick();
    check("full_w4", write_data, 32'h104);
    check("full_pend0", 32'(pending), 32'd0);
    tick();
    check("full_ew_off", 32'(EnableWrite), 32'd0);
    check("full_ovf_sticky", 32'(overflow), 32'd1);
    read_reg2 = 5'd0;

    #3 rst = 1'b1;
    #1;
    check("rst2_ovf", 32'(overflow), 32'd0);
    #2 rst = 1'b0;

    // wrap-around
    for (int k = 1; k <= 10; k++) begin
      send_alu(5'(k), 32'h200 + 32'(k));
      tick();
      check("wrap_pend", 32'(pending), 32'd1);
      if (k > 1) begin
        check("wrap_wreg", 32'(write_reg), 32'(k - 1));
        check("wrap_wdata", write_data, 32'h200 + 32'(k - 1));
      end
    end
    idle();
    tick();
    check("wrap_last_reg", 32'(write_reg), 32'd10);
    check("wrap_last_data", write_data, 32'h20A);
    tick();
    check("wrap_ew_off", 32'(EnableWrite), 32'd0);
    check("wrap_ovf", 32'(overflow), 32'd0);

    // reset mid-drain
    send_mem(5'd11, 32'h311);
    send_alu(5'd12, 32'h312);
    tick();
    send_mem(5'd13, 32'h313);
    send_alu(5'd14, 32'h314);
    tick();
    idle();
    read_reg1 = 5'd14;
    #1;
    check("rmd_pend3", 32'(pending), 32'd3);
    check("rmd_fwd_pre", 32'(fwd1_hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rmd_ew", 32'(EnableWrite), 32'd0);
    check("rmd_pend", 32'(pending), 32'd0);
    check("rmd_fwd", 32'(fwd1_hit), 32'd0);
    check("rmd_fwd_data", fwd1_data, 32'd0);
    check("rmd_ready", 32'(in_ready), 32'd1);
    #2 rst = 1'b0;
    ew_pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (EnableWrite) ew_pulses++;
    end
    check("rmd_no_writes", 32'(ew_pulses), 32'd0);
    check("rmd_pend_after", 32'(pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of queue entries (power of two, at least 2).
REQ-002 Ports, one per line, SHALL be:
  clk  input  1  sole clock; all state updates on posedge.
  rst  input  1  asynchronous, active-high reset.
  alu_valid  input  1  ALU-stage writeback request.
  alu_reg  input  5  ALU destination register.
  alu_data  input  32  ALU result.
  mem_valid  input  1  memory-stage writeback request (load).
  mem_reg  input  5  load destination register.
  mem_data  input  32  load data.
  in_ready  output  1  queue can accept both sources this cycle.
  EnableWrite  output  1  register file write strobe, registered.
  write_reg  output  5  register file write address, registered.
  write_data  output  32  register file write data, registered.
  read_reg1  input  5  decode-stage read address 1.
  read_reg2  input  5  decode-stage read address 2.
  fwd1_hit  output  1  pending write exists for read_reg1.
  fwd1_data  output  32  youngest pending data for read_reg1.
  fwd2_hit  output  1  pending write exists for read_reg2.
  fwd2_data  output  32  youngest pending data for read_reg2.
  pending  output  3  occupied queue entries (0..DEPTH).
  overflow  output  1  sticky error flag.
REQ-003 Reset SHALL be asynchronous and active-high on rst; clock SHALL be clk.

Function
REQ-004 The queue SHALL be a circular FIFO of DEPTH entries {reg[4:0], data[31:0]}, with head/tail pointers wrapping modulo DEPTH.
REQ-005 in_ready SHALL equal (DEPTH - pending >= 2), combinational from registered count only.
REQ-006 On posedge with in_ready=1, each valid request with reg != 0 SHALL be enqueued; requests with reg = 0 SHALL be discarded and consume no slot.
REQ-007 When both sources enqueue in one cycle, the mem entry SHALL be written first (older instruction), the alu entry second.
REQ-008 A valid request arriving with in_ready=0 SHALL be dropped and SHALL set overflow; overflow remains 1 until reset.
REQ-009 On every posedge with pending > 0, the head entry SHALL be popped into write_reg/write_data with EnableWrite=1; with pending = 0, EnableWrite SHALL be 0 and write_reg/write_data SHALL hold.
REQ-010 An entry enqueued at edge N SHALL be eligible for pop no earlier than edge N+1 (no same-edge bypass); minimum request-to-EnableWrite latency is one cycle.
REQ-011 Simultaneous pop and enqueue in one cycle SHALL be permitted; pending SHALL update by (enqueued count - popped count).
REQ-012 Forward lookup SHALL search all valid queue entries plus the output register (when EnableWrite=1), selecting the youngest match; the queue tail side is youngest, the output register oldest.
REQ-013 fwdN_hit SHALL be 0 and fwdN_data SHALL be 0 when read_regN = 0 or no match exists; lookup SHALL be purely combinational.
REQ-014 Lookup SHALL reflect registered state only, not same-cycle alu/mem inputs.

Reset
REQ-015 While rst=1: head, tail, pending = 0; EnableWrite = 0; write_reg = 0; write_data = 0; overflow = 0; all fwd outputs = 0; in_ready = 1.
REQ-016 Reset asserted mid-operation SHALL discard all queued entries immediately; no EnableWrite pulse SHALL follow deassertion until a new request is enqueued.

Verification
REQ-017 Single write: alu_valid, alu_reg=9, alu_data=0x11 at edge 1 -> EnableWrite=1, write_reg=9, write_data=0x11 after edge 2; pending back to 0.
REQ-018 Dual issue ordering: mem(reg=10, 0xAA) and alu(reg=10, 0xBB) same edge -> writes 0xAA then 0xBB on consecutive cycles; fwd for read_reg1=10 returns 0xBB while both pending.
REQ-019 Zero register: alu_valid, alu_reg=0, alu_data=0xFF -> no enqueue, pending stays 0, no EnableWrite, fwd hit on 0 never asserts.
REQ-020 Full/backpressure: DEPTH=4, fill to pending=3 -> in_ready=0; further valid request dropped, overflow=1 sticky; queue drains 3 writes in order.
REQ-021 Wrap-around: 10 back-to-back single requests reg=1..10 -> output sequence 1..10 in order, pointers wrap, overflow stays 0.
REQ-022 Reset mid-drain: pending=3, assert rst asynchronously between edges -> EnableWrite, pending, fwd outputs 0 immediately; no writes after release.
